// File: rtl/coco_pkg.sv
// rtl/coco_pkg.sv - shared defaults, FSM/bucket types and LFSR step for the CocoSketch bucket update stage
package coco_pkg;

  localparam int IDX_W_DEF = 10;
  localparam int KEY_W_DEF = 64;
  localparam int CNT_W_DEF = 32;

  // Right-shift Galois mask for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic [KEY_W_DEF-1:0] key;
    logic [CNT_W_DEF-1:0] count;
  } bucket_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/coco_bucket_ram.sv
// rtl/coco_bucket_ram.sv - simple dual-port bucket RAM, 1-cycle read, old data on read-during-write
module coco_bucket_ram
  import coco_pkg::*;
#(
  parameter int ADDR_W = IDX_W_DEF,
  parameter int DATA_W = KEY_W_DEF + CNT_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/coco_bucket_update.sv
// rtl/coco_bucket_update.sv - CocoSketch single-row bucket update stage behind the CRC32 hash stage
// Optional statistics counters enabled by defining COCO_STATS_EN.
module coco_bucket_update
  import coco_pkg::*;
#(
  parameter int          IDX_W     = IDX_W_DEF,
  parameter int          KEY_W     = KEY_W_DEF,
  parameter int          CNT_W     = CNT_W_DEF,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] data,
  input  logic             datavalid,
  input  logic [31:0]      checksum,
  input  logic             crcvalid,
  output logic             in_ready,
`ifdef COCO_STATS_EN
  output logic [31:0]      stat_inserts,
  output logic [31:0]      stat_replaces,
  output logic [31:0]      stat_drops,
`endif
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_index,
  output logic [KEY_W-1:0] upd_key,
  output logic [CNT_W-1:0] upd_count,
  output logic             upd_replaced
);

  localparam int          BW      = KEY_W + CNT_W;
  localparam int          PW      = 32 + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0] SEED    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic [KEY_W-1:0]  key_d1_q;
  logic              kv_d1_q;
  logic              a_valid_q;
  logic [IDX_W-1:0]  a_idx_q;
  logic [KEY_W-1:0]  a_key_q;
  logic [31:0]       lfsr_q;
  logic              upd_valid_q, upd_replaced_q;
  logic [IDX_W-1:0]  upd_index_q;
  logic [KEY_W-1:0]  upd_key_q;
  logic [CNT_W-1:0]  upd_count_q;

  logic              a_valid;
  logic              fwd;
  logic [KEY_W-1:0]  cur_key, new_key;
  logic [CNT_W-1:0]  cur_cnt, new_cnt;
  logic [PW-1:0]     prod;
  logic              replace;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [BW-1:0]     ram_wdata, ram_rdata;
  logic              unused_bits;

  assign in_ready    = (state_q == RUN);
  assign a_valid     = crcvalid & kv_d1_q;
  assign unused_bits = ^{checksum[31:IDX_W], prod[31:0]};

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // The RAM returns stale data when last cycle's write hit the same bucket; take the registered result.
  always_comb begin
    fwd     = upd_valid_q && (upd_index_q == a_idx_q);
    cur_key = fwd ? upd_key_q   : ram_rdata[BW-1:CNT_W];
    cur_cnt = fwd ? upd_count_q : ram_rdata[CNT_W-1:0];
    new_cnt = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
    prod    = PW'(lfsr_q) * PW'(new_cnt);
    replace = (cur_key != a_key_q) && (prod[PW-1:32] == '0);
    new_key = replace ? a_key_q : cur_key;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = a_idx_q;
    ram_wdata = {new_key, new_cnt};
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_q;
      ram_wdata = '0;
    end else if (a_valid_q) begin
      ram_we    = 1'b1;
    end
  end

  coco_bucket_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (BW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (checksum[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= INIT;
      sweep_q        <= '0;
      key_d1_q       <= '0;
      kv_d1_q        <= 1'b0;
      a_valid_q      <= 1'b0;
      a_idx_q        <= '0;
      a_key_q        <= '0;
      lfsr_q         <= SEED;
      upd_valid_q    <= 1'b0;
      upd_index_q    <= '0;
      upd_key_q      <= '0;
      upd_count_q    <= '0;
      upd_replaced_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      key_d1_q    <= data;
      kv_d1_q     <= datavalid & in_ready;
      a_valid_q   <= a_valid;
      a_idx_q     <= checksum[IDX_W-1:0];
      a_key_q     <= key_d1_q;
      upd_valid_q <= a_valid_q;
      if (a_valid_q) begin
        lfsr_q         <= lfsr_next(lfsr_q);
        upd_index_q    <= a_idx_q;
        upd_key_q      <= new_key;
        upd_count_q    <= new_cnt;
        upd_replaced_q <= replace;
      end
    end
  end

  assign upd_valid    = upd_valid_q;
  assign upd_index    = upd_index_q;
  assign upd_key      = upd_key_q;
  assign upd_count    = upd_count_q;
  assign upd_replaced = upd_replaced_q;

`ifdef COCO_STATS_EN
  logic [31:0] ins_q, rep_q, drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ins_q  <= '0;
      rep_q  <= '0;
      drop_q <= '0;
    end else begin
      if (a_valid_q)              ins_q  <= ins_q + 1'b1;
      if (a_valid_q && replace)   rep_q  <= rep_q + 1'b1;
      if (datavalid && !in_ready) drop_q <= drop_q + 1'b1;
    end
  end

  assign stat_inserts  = ins_q;
  assign stat_replaces = rep_q;
  assign stat_drops    = drop_q;
`endif

endmodule
